tri_bus_arbiter_drv: RTL
========================

# tri_bus_arbiter_drv

Parametrised multi-channel tri-state bus driver with round-robin ownership. NCH channels share one WIDTH-bit inout bus. Each bit is driven through a per-channel `bufif1` gate whose control is a registered one-hot output enable. Ownership changes always pass through a guaranteed Z turnaround window, so two drivers never overlap. The block sits between gate-level bus segments and the channel logic that requests the bus.

## Interface
- `WIDTH`, 8: bus width in bits (1..64).
- `NCH`, 4: number of channels (2..16).
- `TURN`, 1: Z turnaround cycles between owners (1..15).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req` input NCH: per-channel bus request, level-sensitive, sampled on `clk`.
- `din` input NCH*WIDTH: channel k data in bits [k*WIDTH +: WIDTH].
- `gnt` output NCH: registered one-hot grant; it is also the `bufif1` control for channel k.
- `bus` inout WIDTH: shared tri-state bus.
- `bus_in` output WIDTH: observed bus value.
- `busy` output 1: high while any grant is active or a turnaround is in progress.

## Operation
- The FSM has three states: IDLE, DRIVE and TURN.
- **IDLE**
  - If `req` is nonzero, pick the first requesting channel at or after `ptr` (cyclic search), where `ptr` is the round-robin pointer.
  - Set `gnt` one-hot for that channel and go to DRIVE.
- **DRIVE**
  - The owner keeps the bus while its `req` stays high. Other channels' requests are ignored.
  - When the owner's `req` is sampled low: clear `gnt`, set `ptr` = owner+1 mod NCH, load the turnaround counter with `TURN`, and go to TURN.
- **TURN**
  - `gnt` = 0 and the bus is Z. The counter decrements each cycle.
  - At count 1, go to IDLE. The next arbitration happens in that IDLE cycle.
- **Bus drive**
  - `bus[i]` is driven by `bufif1(bus[i], din[k*WIDTH+i], gnt[k])` for every k.
  - Because `gnt` is registered and one-hot, at most one driver is active at any time.
  - `din` passes through combinationally while granted. It is not registered.
- **Boundary conditions**
  - Simultaneous requests: the lowest index at or after `ptr` wins.
  - `ptr` wraps from NCH-1 to 0.
  - If the owner drops `req` while others are requesting, TURN is still fully honoured.
  - A request that drops before it is granted is lost; nothing is queued.
  - Reset asserted mid-DRIVE or mid-TURN: `gnt` clears immediately (asynchronously) and the bus floats in the same instant.

## Timing
- **Reset values:** `gnt` = 0, `busy` = 0, `bus` = Z, state = IDLE, `ptr` = 0, turnaround counter = 0, `bus_in` keeper register = 0 (when the keeper is compiled in).
- **Request to grant:** a `req` sampled high at edge n in IDLE gives `gnt` high after edge n. The bus is driven in that same cycle.
- **Release:** `req` sampled low at edge n gives `gnt` = 0 after edge n.
- **Handoff:** the next owner's `gnt` rises after edge n+TURN+1. That is TURN Z cycles plus one IDLE arbitration cycle.
- **Minimum ownership:** one cycle.
- **`busy`:** a combinational decode of state, high in DRIVE and TURN.

## Configuration
- Controlled by the macro `TRI_BUS_KEEPER_EN`.
- **Defined:**
  - A WIDTH-bit keeper register captures the bus on every edge where any `gnt` is high.
  - `bus_in` = `bus` while granted; otherwise it shows the keeper value. `bus_in` therefore never presents Z or X after the first drive.
  - The keeper resets to 0.
- **Undefined:**
  - `bus_in` = `bus` directly and shows Z whenever the bus is undriven.
  - No keeper register exists.

## Test plan
- **Reset and idle:** apply reset with WIDTH=8, NCH=4, TURN=1 -> `gnt`=0000, `bus`=zzzzzzzz, `busy`=0; `bus_in`=00 with the keeper, zz without.
- **Single owner:** `req`=0010, `din` ch1=0xA5 -> after one edge `gnt`=0010 and `bus`=0xA5. Drop `req` -> `gnt`=0000, bus Z for exactly 1 cycle, `busy` falls after the TURN cycle.
- **Round-robin fairness:** `req`=1111 held constantly, each owner dropping `req` for one cycle after 2 cycles of ownership -> grant order 0,1,2,3,0. Never two `gnt` bits high, and at least one Z cycle between owners.
- **Turnaround length:** with TURN=3, ch0 releases while ch2 is requesting -> 3 Z cycles plus 1 IDLE cycle, then `gnt`=0100. No driver contention (no X on `bus`) at any point.
- **Reset mid-drive:** ch3 owns the bus with `din`=0x3C and `rst_n` falls between edges -> `gnt`=0000 and `bus` Z immediately. After release, `ptr`=0, so ch0 wins over ch3 when both request.
- **Keeper:** with the macro defined, ch2 drives 0x5A and then releases -> `bus_in` stays 0x5A through TURN and IDLE. Without the macro -> `bus_in`=zz.

Source files
------------

// File: rtl/tri_bus_arbiter_drv.sv
// tri_bus_arbiter_drv: round-robin owner of a shared WIDTH-bit tri-state bus.
// Each channel drives the bus through per-bit bufif1 gates enabled by a registered
// one-hot grant. Every ownership change passes through TURN Z cycles plus one
// arbitration cycle, so two drivers can never overlap.
// Optional feature: define TRI_BUS_KEEPER_EN to add a bus keeper on bus_in.
module tri_bus_arbiter_drv #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned TURN  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         req,
    input  logic [NCH*WIDTH-1:0]   din,
    output logic [NCH-1:0]         gnt,
    inout  wire  [WIDTH-1:0]       bus,
    output logic [WIDTH-1:0]       bus_in,
    output logic                   busy
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StTurn
    } state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  gnt_q, gnt_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            found;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   cand;
    int unsigned     idx;

    // State, grant, owner, pointer and turnaround counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Cyclic search for the first requester at or after ptr, then next-state logic.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        found   = 1'b0;
        pick    = '0;
        cand    = '0;
        idx     = 0;

        for (int unsigned i = 0; i < NCH; i++) begin
            idx  = (32'(ptr_q) + i) % NCH;
            cand = PW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    owner_d     = pick;
                    state_d     = StDrive;
                end
            end
            StDrive: begin
                // Only the owner's request matters while it holds the bus.
                if (!req[owner_q]) begin
                    gnt_d   = '0;
                    ptr_d   = (owner_q == PW'(NCH - 1)) ? '0 : owner_q + PW'(1);
                    cnt_d   = CW'(TURN);
                    state_d = StTurn;
                end
            end
            StTurn: begin
                gnt_d = '0;
                if (cnt_q <= CW'(1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    assign gnt  = gnt_q;
    assign busy = (state_q != StIdle);

    // Per-channel, per-bit tri-state drivers; the registered one-hot grant is the enable.
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            bufif1 u_drv (bus[i], din[k*WIDTH+i], gnt_q[k]);
        end
    end

`ifdef TRI_BUS_KEEPER_EN
    logic [WIDTH-1:0] keep_q;

    // Keeper follows the bus on every edge where some channel owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keep_q <= '0;
        end else if (|gnt_q) begin
            keep_q <= bus;
        end
    end

    assign bus_in = (|gnt_q) ? bus : keep_q;
`else
    assign bus_in = bus;
`endif

endmodule
